// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment driver with double-buffered BCD input.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_segment_scanner #(
    parameter int unsigned REFRESH_COUNT = 1600,
    parameter int unsigned BLANK_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  led_out,
    output logic        dp_out,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    localparam int unsigned CW = $clog2(REFRESH_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          run_q;
    logic [15:0]   pend_q, act_q, act_d;
    logic [3:0]    pdp_q, adp_q, adp_d;
    logic          wrap, xfer;
    logic [3:0]    cur;
    logic          cur_dp, show;
    logic [6:0]    seg, led_d;
    logic          dp_d, fs_d;
    logic [3:0]    en_d;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Outputs are registered from the next (i, c) so they line up with the state they describe.
    always_comb begin
        wrap  = run_q && (cnt_q == CNT_LAST);
        xfer  = wrap && (idx_q == 2'd3);
        cnt_d = (!run_q || wrap) ? '0 : cnt_q + CW'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        act_d = xfer ? pend_q : act_q;
        adp_d = xfer ? pdp_q : adp_q;

        cur    = act_d[{idx_d, 2'b00} +: 4];
        cur_dp = adp_d[idx_d];
        seg    = bcd_to_seg(cur);
        show   = (cur < 4'd10);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_d != 2'd0) && !cur_dp && ((act_d >> {idx_d, 2'b00}) == '0)) begin
            show = 1'b0;
        end
`endif
        led_d = show ? seg : 7'b0000000;
        dp_d  = show && cur_dp;
        en_d  = (cnt_d < CNT_BLANK) ? 4'b0000 : (4'b0001 << idx_d);
        fs_d  = (cnt_d == '0) && (idx_d == 2'd0);
    end

    // The first edge after reset only arms the scanner, so (0,0) gets its frame_start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            run_q       <= 1'b0;
            pend_q      <= 16'h0000;
            act_q       <= 16'h0000;
            pdp_q       <= 4'b0000;
            adp_q       <= 4'b0000;
            led_out     <= 7'b0111111;
            dp_out      <= 1'b0;
            digit_en    <= 4'b0000;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            run_q       <= 1'b1;
            act_q       <= act_d;
            adp_q       <= adp_d;
            if (load) begin
                pend_q <= digits_in;
                pdp_q  <= dp_in;
            end
            led_out     <= led_d;
            dp_out      <= dp_d;
            digit_en    <= en_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized and directed bench for seven_segment_scanner against a frame-level model.
// Expectations are derived from elapsed cycles since the first active cycle.
module tb_seven_segment_scanner;

    localparam int R = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic [6:0]  led_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int checks = 0;
    int passes = 0;

    // Model: t counts cycles since the first active cycle.
    bit          started = 1'b0;
    int          t = 0;
    logic [15:0] m_pend = 16'h0000, m_act = 16'h0000;
    logic [3:0]  m_pdp = 4'b0000, m_adp = 4'b0000;

    seven_segment_scanner #(.REFRESH_COUNT(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .led_out(led_out), .dp_out(dp_out), .digit_en(digit_en), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int cur_i();
        return (t / R) % 4;
    endfunction

    function automatic int cur_c();
        return t % R;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    endtask

    task automatic check_outputs();
        logic [6:0] e_led;
        logic       e_dp, e_fs, blank;
        logic [3:0] e_en;
        int         i, c, d;
        if (reset || !started) begin
            e_led = 7'b0111111; e_dp = 1'b0; e_en = 4'b0000; e_fs = 1'b0;
        end else begin
            i = cur_i();
            c = cur_c();
            d = int'((m_act >> (4 * i)) & 16'h000F);
            blank = (d > 9);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (m_act >> (4 * i)) == 16'h0000 && !m_adp[i]) blank = 1'b1;
`endif
            e_led = blank ? 7'b0000000 : seg_of(d);
            e_dp  = !blank && m_adp[i];
            e_en  = (c < B) ? 4'b0000 : (4'b0001 << i);
            e_fs  = (t % (4 * R)) == 0;
        end
        check("led_out", led_out, e_led);
        check("dp_out", {6'b0, dp_out}, {6'b0, e_dp});
        check("digit_en", {3'b0, digit_en}, {3'b0, e_en});
        check("frame_start", {6'b0, frame_start}, {6'b0, e_fs});
    endtask

    // Called at a negedge: check, drive inputs, advance one clock, update model.
    task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] p);
        check_outputs();
        load = ld;
        digits_in = ld ? d : 16'($urandom);
        dp_in = ld ? p : 4'($urandom);
        @(posedge clk);
        if (!reset) begin
            if (started && cur_i() == 3 && cur_c() == R - 1) begin
                m_act = m_pend;
                m_adp = m_pdp;
            end
            if (ld) begin
                m_pend = d;
                m_pdp  = p;
            end
            if (started) t++;
            else begin
                started = 1'b1;
                t = 0;
            end
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to(input int ti, input int tc);
        for (int k = 0; k < 4 * R && !(started && cur_i() == ti && cur_c() == tc); k++)
            cycle(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        run(11);

        // Mid-slot reset discards a pending load and blanks immediately.
        cycle(1'b1, 16'h9999, 4'hF);
        reset = 1'b1;
        started = 1'b0; t = 0;
        m_pend = 16'h0; m_act = 16'h0; m_pdp = 4'h0; m_adp = 4'h0;
        #1;
        check("async_blank", {3'b0, digit_en}, 7'd0);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        run(4 * R);

        // Scan order of 1234 loaded before a boundary.
        run_to(3, 5);
        cycle(1'b1, 16'h1234, 4'h0);
        run(5 * R);

        // Mid-frame load at i=1 takes effect only after the next frame_start.
        run_to(1, 3);
        cycle(1'b1, 16'h5678, 4'h0);
        run(6 * R);

        // Load coincident with the transfer cycle.
        run_to(3, 6);
        cycle(1'b1, 16'h4321, 4'h0);
        cycle(1'b1, 16'h8765, 4'h0);
        run(9 * R);

        // Invalid BCD with decimal point request.
        run_to(2, 0);
        cycle(1'b1, 16'h00A0, 4'b0010);
        run(9 * R);

        // Leading-zero candidate.
        cycle(1'b1, 16'h0042, 4'b0000);
        run(9 * R);

        // Random loads at random times, including multiple loads per frame.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                cycle(1'b1, ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                      {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                      4'($urandom));
            end else begin
                cycle(1'b0, 16'h0, 4'h0);
            end
        end
        cycle(1'b1, 16'h0000, 4'b0000);
        run(9 * R);
        cycle(1'b1, 16'h0100, 4'b1000);
        run(9 * R);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 1600: clock cycles per digit slot; legal range 4..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: dead-time cycles at the start of each slot; legal range 1..REFRESH_COUNT-2.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port digits_in, input, 16: four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 SHALL have port dp_in, input, 4: decimal-point request per digit, bit n for digit n.
REQ-007 SHALL have port load, input, 1: single-cycle strobe capturing digits_in and dp_in.
REQ-008 SHALL have port led_out, output, 7: segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port dp_out, output, 1: decimal-point segment, active-high.
REQ-010 SHALL have port digit_en, output, 4: one-hot digit select, active-high; all-zero while blanked.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL keep a slot counter c (0..REFRESH_COUNT-1) and a digit index i (0..3); c increments every cycle, wraps to 0 after REFRESH_COUNT-1, and i increments on that wrap, 3 wrapping to 0.
REQ-013 SHALL register all outputs; the outputs in a cycle reflect the (i, c) state held in that same cycle.
REQ-014 SHALL drive digit_en = 4'b0000 when c < BLANK_CYCLES, otherwise one-hot bit i.
REQ-015 SHALL drive led_out from active digit i using this map: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-016 SHALL drive led_out = 7'b0000000 and dp_out = 0 for BCD values 10..15.
REQ-017 SHALL drive dp_out from active dp bit i, gated by the same valid-BCD rule.
REQ-018 SHALL double-buffer the inputs: load writes a pending register; pending copies to the active register only in the cycle where i=3 and c=REFRESH_COUNT-1.
REQ-019 SHALL mean a load issued mid-frame never changes the frame in progress.
REQ-020 SHALL, when load coincides with the transfer cycle, give active the old pending value and pending the new digits_in; the new value then appears one frame later.
REQ-021 SHALL keep the last load when several loads occur within one frame; earlier loads are discarded.
REQ-022 SHALL assert frame_start for exactly the one cycle where i=0 and c=0.

Reset
REQ-023 SHALL, while reset is high, clear c, i, pending and active to 0 and set digit_en=4'b0000, frame_start=0, dp_out=0 and led_out=7'b0111111.
REQ-024 SHALL, when reset deasserts, start at i=0, c=0 and pulse frame_start in the first active cycle.
REQ-025 SHALL, on reset asserted mid-slot, blank digit_en immediately and asynchronously, and discard any pending load.

Configuration
REQ-026 SHALL, with LEADING_ZERO_BLANK_EN defined, treat digit n (n=3,2,1) as blank (led_out=0, dp_out=0, digit_en still scanned) when it and all higher active digits are zero and its dp bit is 0; digit 0 SHALL always display.
REQ-027 SHALL, without LEADING_ZERO_BLANK_EN, display every valid digit including leading zeros.

Verification (REFRESH_COUNT=8, BLANK_CYCLES=2 unless noted)
REQ-028 SHALL cover reset: assert reset mid-slot -> digit_en=0000 the same cycle; the next cycle led_out=0111111 and frame_start=0.
REQ-029 SHALL cover the scan order: load 16'h1234 before a frame boundary -> the next frame shows digit_en 0001/0010/0100/1000 with led_out 1100110/1001111/1011011/0000110, each enabled for 6 of 8 cycles.
REQ-030 SHALL cover a mid-frame load: load 16'h5678 at i=1 -> the current frame still shows 1234 and 5678 appears after the next frame_start.
REQ-031 SHALL cover coincident load: load at i=3, c=7 -> the old pending is displayed next frame and the new value the frame after.
REQ-032 SHALL cover invalid BCD: load 16'h00A0, dp_in=4'b0010 -> digit 1 shows led_out=0000000 and dp_out=0.
REQ-033 SHALL cover the macro: load 16'h0042 -> with LEADING_ZERO_BLANK_EN, digits 3 and 2 show 0000000; without it, both show 0111111.
